// File: rtl/m31_pkg.sv
// Mersenne-31 field types, constants and the shared 32-bit fold helper.
// M31_SBOX_LAT depends on the M31_SBOX_RC_EN build macro.
package m31_pkg;

   typedef logic [30:0] m31_t;

   localparam m31_t P_M31       = 31'h7FFFFFFF;
   localparam int   M31_MUL_LAT = 4;

`ifdef M31_SBOX_RC_EN
   localparam int M31_SBOX_LAT = 1 + 3 * M31_MUL_LAT;
`else
   localparam int M31_SBOX_LAT = 3 * M31_MUL_LAT;
`endif

   // Inputs are below 2*P, so a single fold of bit 31 lands in [0, P] and one compare finishes it
   function automatic m31_t m31_fold(input logic [31:0] v);
      m31_t t;
      t = v[30:0] + {30'd0, v[31]};
      return (t == P_M31) ? '0 : t;
   endfunction

endpackage

// File: rtl/m31_sbox5_pipe_if.sv
// Streaming bus of the M31 S-box stage: element, round constant and tag in, result and tag out.
interface m31_sbox5_pipe_if #(
   parameter int TAG_W = 4
);

   logic               in_valid_i;
   m31_pkg::m31_t      x_i;
   m31_pkg::m31_t      rc_i;
   logic [TAG_W-1:0]   tag_i;
   logic               out_valid_o;
   m31_pkg::m31_t      y_o;
   logic [TAG_W-1:0]   tag_o;

   modport master (
      output in_valid_i, x_i, rc_i, tag_i,
      input  out_valid_o, y_o, tag_o
   );

   modport slave (
      input  in_valid_i, x_i, rc_i, tag_i,
      output out_valid_o, y_o, tag_o
   );

endinterface

// File: rtl/m31_add.sv
// Combinational canonical addition in the Mersenne-31 field.
module m31_add
   import m31_pkg::*;
(
   input  m31_t a,
   input  m31_t b,
   output m31_t s
);

   logic [31:0] raw_sum;

   assign raw_sum = {1'b0, a} + {1'b0, b};
   assign s       = m31_fold(raw_sum);

endmodule

// File: rtl/m31_delay_line.sv
// Parameterised DEPTH x WIDTH register chain with asynchronous active-low clear.
module m31_delay_line #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 31
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= d;
         for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/m31_mul.sv
// Four-stage pipelined Mersenne-31 multiplier: operand capture, 62-bit product, fold, canonicalise.
module m31_mul
   import m31_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  m31_t a,
   input  m31_t b,
   output m31_t p
);

   m31_t        a_q;
   m31_t        b_q;
   logic [61:0] prod_q;
   logic [31:0] sum_q;

   // 2^31 == 1 mod P, so the product's high and low 31-bit halves simply add
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         prod_q <= '0;
         sum_q  <= '0;
         p      <= '0;
      end else begin
         a_q    <= a;
         b_q    <= b;
         prod_q <= 62'(a_q) * 62'(b_q);
         sum_q  <= {1'b0, prod_q[30:0]} + {1'b0, prod_q[61:31]};
         p      <= m31_fold(sum_q);
      end
   end

endmodule

// File: rtl/m31_sbox5_pipe.sv
// Poseidon2 S-box stage y = (x + rc)^5 mod (2^31 - 1), one element per cycle, fixed latency.
// Build macro M31_SBOX_RC_EN adds the registered round-constant add (latency 13, else 12).
module m31_sbox5_pipe
   import m31_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   m31_sbox5_pipe_if.slave       bus
);

   m31_t             s;
   m31_t             sq;
   m31_t             q;
   m31_t             s_d8;
   m31_t             y;
   logic [TAG_W:0]   vt_q;

`ifdef M31_SBOX_RC_EN
   m31_t s_sum;
   m31_t s_q;

   m31_add u_rc_add (
      .a (bus.x_i),
      .b (bus.rc_i),
      .s (s_sum)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s_q <= '0;
      else        s_q <= s_sum;
   end

   assign s = s_q;
`else
   logic unused_rc;

   assign unused_rc = ^bus.rc_i;
   assign s         = bus.x_i;
`endif

   m31_mul u_mul_sq (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (s),
      .b     (s),
      .p     (sq)
   );

   m31_mul u_mul_q (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (sq),
      .b     (sq),
      .p     (q)
   );

   // s must wait out the two squaring multipliers so it meets s^4 at the last multiplier
   m31_delay_line #(
      .DEPTH (2 * M31_MUL_LAT),
      .WIDTH ($bits(m31_t))
   ) u_s_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (s),
      .q     (s_d8)
   );

   m31_mul u_mul_y (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (q),
      .b     (s_d8),
      .p     (y)
   );

   m31_delay_line #(
      .DEPTH (M31_SBOX_LAT),
      .WIDTH (TAG_W + 1)
   ) u_vt_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .d     ({bus.in_valid_i, bus.tag_i}),
      .q     (vt_q)
   );

   assign bus.out_valid_o = vt_q[TAG_W];
   assign bus.tag_o       = vt_q[TAG_W-1:0];
   assign bus.y_o         = y;

endmodule

// File: tb/tb_m31_sbox5_pipe.sv
// Self-checking bench for m31_sbox5_pipe; honours the M31_SBOX_RC_EN build macro.
module tb_m31_sbox5_pipe;
   import m31_pkg::*;

   localparam int TAG_W = 4;
`ifdef M31_SBOX_RC_EN
   localparam int L = 13;
`else
   localparam int L = 12;
`endif

   typedef struct {
      bit               v;
      logic [30:0]      y;
      logic [TAG_W-1:0] tag;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_tests  = 0;
   int   n_fail   = 0;
   int   edge_idx = 0;
   exp_t hist [4096];

   m31_sbox5_pipe_if #(.TAG_W(TAG_W)) bus ();

   m31_sbox5_pipe #(.TAG_W(TAG_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_tests++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, edge_idx, actual, expected);
      end
   endtask

   function automatic logic [30:0] golden(input longint x, input longint rc);
      longint p = 64'h7FFFFFFF;
      longint s, s2, s4;
`ifdef M31_SBOX_RC_EN
      s = (x + rc) % p;
`else
      s = x % p;
`endif
      s2 = (s * s) % p;
      s4 = (s2 * s2) % p;
      return 31'((s4 * s) % p);
   endfunction

   // Checks what the previous edge produced, then presents one input for the next edge
   task automatic applyStimulus(input bit v, input logic [30:0] x, input logic [30:0] rc,
                                input logic [TAG_W-1:0] tag, input logic [30:0] exp_y);
      int src;
      src = edge_idx - L;
      if (src >= 0 && hist[src].v) begin
         checkOutput("out_valid", 64'(bus.out_valid_o), 64'd1);
         checkOutput("y", 64'(bus.y_o), 64'(hist[src].y));
         checkOutput("tag", 64'(bus.tag_o), 64'(hist[src].tag));
      end else begin
         checkOutput("out_valid_idle", 64'(bus.out_valid_o), 64'd0);
         checkOutput("y_known", 64'($isunknown(bus.y_o)), 64'd0);
      end
      bus.in_valid_i = v;
      bus.x_i        = x;
      bus.rc_i       = rc;
      bus.tag_i      = tag;
      hist[edge_idx] = '{v, exp_y, tag};
      @(posedge clk);
      edge_idx++;
      @(negedge clk);
   endtask

   task automatic applyReset(input int cycles);
      rst_n          = 1'b0;
      bus.in_valid_i = 1'b0;
      bus.x_i        = '0;
      bus.rc_i       = '0;
      bus.tag_i      = '0;
      for (int j = 0; j < edge_idx; j++) hist[j].v = 1'b0;
      #1;
      checkOutput("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
      checkOutput("rst_y", 64'(bus.y_o), 64'd0);
      checkOutput("rst_tag", 64'(bus.tag_o), 64'd0);
      for (int c = 0; c < cycles; c++) begin
         hist[edge_idx].v = 1'b0;
         @(posedge clk);
         edge_idx++;
         @(negedge clk);
      end
      rst_n = 1'b1;
   endtask

   task automatic idle(input int cycles);
      for (int c = 0; c < cycles; c++) applyStimulus(1'b0, '0, '0, '0, '0);
   endtask

   initial begin
      rst_n          = 1'b1;
      bus.in_valid_i = 1'b0;
      bus.x_i        = '0;
      bus.rc_i       = '0;
      bus.tag_i      = '0;
      #2;
      applyReset(2);

      // Fixed points with rc = 0
      applyStimulus(1'b1, 31'd0, 31'd0, 4'd3, 31'd0);
      idle(1);
      applyStimulus(1'b1, 31'd1, 31'd0, 4'd3, 31'd1);
      applyStimulus(1'b1, 31'h7FFFFFFE, 31'd0, 4'd3, 31'h7FFFFFFE);
      idle(3);

      // Back-to-back stream with one input bubble
      applyStimulus(1'b1, 31'd2, 31'd0, 4'd1, 31'd32);
      applyStimulus(1'b1, 31'd3, 31'd0, 4'd2, 31'd243);
      applyStimulus(1'b0, 31'd0, 31'd0, 4'd0, 31'd0);
      applyStimulus(1'b1, 31'd4, 31'd0, 4'd5, 31'd1024);
      applyStimulus(1'b1, 31'd5, 31'd0, 4'd6, 31'd3125);

`ifdef M31_SBOX_RC_EN
      applyStimulus(1'b1, 31'd1, 31'd1, 4'd7, 31'd32);
      applyStimulus(1'b1, 31'h7FFFFFFE, 31'd1, 4'd8, 31'd0);
      applyStimulus(1'b1, 31'h7FFFFFFE, 31'd2, 4'd9, 31'd1);
`else
      applyStimulus(1'b1, 31'd1, 31'd5, 4'd7, 31'd1);
      applyStimulus(1'b1, 31'h7FFFFFFE, 31'd5, 4'd8, 31'h7FFFFFFE);
      applyStimulus(1'b1, 31'h7FFFFFFE, 31'd5, 4'd9, 31'h7FFFFFFE);
`endif
      idle(L + 1);

      // Random canonical operands with random valid
      for (int i = 0; i < 1000; i++) begin
         logic [30:0] rx, rrc;
         bit          rv;
         rx  = 31'($urandom_range(0, 32'h7FFFFFFE));
         rrc = 31'($urandom_range(0, 32'h7FFFFFFE));
         rv  = ($urandom_range(0, 3) != 0);
         applyStimulus(rv, rx, rrc, 4'($urandom_range(0, 15)), golden(longint'(rx), longint'(rrc)));
      end
      idle(L + 1);

      // Reset in the middle of a stream discards everything in flight
      for (int i = 0; i < 6; i++)
         applyStimulus(1'b1, 31'(i + 2), 31'd0, 4'(i + 1), golden(longint'(i + 2), 0));
      applyReset(2);
      applyStimulus(1'b1, 31'd3, 31'd0, 4'd9, 31'd243);
      idle(L + 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/m31_sbox5_pipe.md
# m31_sbox5_pipe

Fully pipelined Poseidon2 S-box stage over the Mersenne-31 field: computes y = (x + rc)^5 mod P_M31, where P_M31 = 2^31 − 1. It sits immediately downstream of the m31_add / m31_mul primitives, instantiates them, and feeds the linear (MDS) layer of a Poseidon2 round. It accepts one element per cycle, has a fixed latency, and carries a sideband tag alongside each element.

## Interface
- TAG_W, default 4: width of the sideband tag (lane/state index); must be ≥ 1.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid_i  input  1  input element valid this cycle.
- x_i  input  m31_t (31)  state element; canonical, range [0, P_M31−1].
- rc_i  input  m31_t (31)  round constant; canonical. Ignored when M31_SBOX_RC_EN is undefined.
- tag_i  input  TAG_W  sideband tag, captured with x_i.
- out_valid_o  output  1  result valid.
- y_o  output  m31_t (31)  (x + rc)^5 mod P_M31, canonical.
- tag_o  output  TAG_W  tag aligned with y_o.

## Operation
- Stage A (RC add, present only with M31_SBOX_RC_EN): s = m31_add(x_i, rc_i), registered; 1 cycle.
- Stage B: sq = m31_mul(s, s); 4 cycles.
- Stage C: q = m31_mul(sq, sq); 4 cycles.
- Stage D: y = m31_mul(q, s_d8); 4 cycles. s_d8 is s delayed by 8 registers, aligned with q.
- in_valid_i and tag_i travel through a shift register whose depth equals the total latency; out_valid_o and tag_o are the final taps.
- No backpressure. The downstream stage must accept every cycle in which out_valid_o = 1.
- Data registers advance every cycle regardless of valid. When out_valid_o = 0, y_o is don't-care for checking, but must never be X after reset.
- All arithmetic is canonical. 0x7FFFFFFF never appears on y_o. Inputs equal to 0x7FFFFFFF are out of contract.
- The mapping is a bijection on the field (gcd(5, P−1) = 1). Fixed points include 0, 1 and P−1.

## Timing
- Latency L = 13 cycles with M31_SBOX_RC_EN, 12 without: an input sampled at edge n appears at edge n+L.
- Throughput: one element per cycle, unbounded back-to-back streaming, no bubbles inserted.
- Reset (rst_n = 0, asynchronous): out_valid_o = 0, y_o = 0, tag_o = 0. All valid and tag shift registers, the delay line and the stage-A register clear to 0.
- Reset mid-stream: all in-flight elements are discarded. After rst_n rises, out_valid_o stays 0 until L edges after the first new valid input.
- Valid gaps propagate exactly: a one-cycle bubble at the input yields a one-cycle bubble at the output, L cycles later.

## Configuration
- M31_SBOX_RC_EN defined:
  - stage A is instantiated;
  - y = (x_i + rc_i)^5;
  - L = 13.
- M31_SBOX_RC_EN undefined:
  - stage A is removed and s = x_i directly;
  - rc_i stays on the port list but is unused;
  - y = x_i^5;
  - L = 12.
- The bench reads the same macro to select the expected latency and golden model.

## Structure
- m31_pkg holds:
  - m31_t and P_M31 (existing);
  - new constants M31_MUL_LAT = 4 and M31_SBOX_LAT, the latter computed under the macro.
- Reuse m31_add (combinational) and three m31_mul instances (4-cycle, reset to 0).
- One new sub-module, m31_delay_line, a parameterized depth × width register chain with asynchronous reset. It is used for s_d8 and for the valid/tag pipe.

## Test plan
- Reset check: assert rst_n low → out_valid_o = 0, y_o = 0, tag_o = 0 immediately, before any clock edge.
- Fixed points (rc = 0): x = 0, 1, 0x7FFFFFFE, each tag 3 → y = 0, 1, 0x7FFFFFFE after exactly L cycles, tag_o = 3.
- Back-to-back streaming: x = 2, 3, 4, 5 on consecutive cycles → y = 32, 243, 1024, 3125 on consecutive cycles starting at L. Include one bubble and check the output bubble is at the matching position.
- RC add (macro on): x = 1, rc = 1 → 32. x = 0x7FFFFFFE, rc = 1 → 0. x = 0x7FFFFFFE, rc = 2 → 1. With the macro off, the same x with rc = 5 → rc ignored: 1, 0x7FFFFFFE, 0x7FFFFFFE.
- Random: 1000 canonical x and rc values with random valid → compare against longint golden model ((x + rc) mod P)^5 mod P, with tag ordering preserved.
- Reset mid-stream: drive 6 valid inputs, pull rst_n low for 2 cycles, release → no out_valid_o pulse for any pre-reset element. The first post-reset input emerges at exactly L cycles.
